// File: rtl/des_round_ctrl_if.sv
// ---------------------------------------------------------------------------
// des_round_ctrl_if
// Bundles the signals between the DES round sequencer and its surroundings.
//   Input side  : in_valid / in_ready / in_decrypt / in_block / in_key_cd
//   Round side  : rnd_active / rnd_idx / rnd_r / rnd_cd out, f_result back
//   Output side : out_valid / out_ready / out_block
// The "slave" modport is the sequencer's view. The "master" modport is the
// view of the surrounding core: the IP/PC-1 stage, the f datapath and the
// FP stage.
// ---------------------------------------------------------------------------
interface des_round_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_decrypt;
    logic [63:0] in_block;
    logic [55:0] in_key_cd;

    logic        rnd_active;
    logic [3:0]  rnd_idx;
    logic [31:0] rnd_r;
    logic [55:0] rnd_cd;
    logic [31:0] f_result;

    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_block;

    modport master (
        output in_valid, in_decrypt, in_block, in_key_cd, f_result, out_ready,
        input  in_ready, rnd_active, rnd_idx, rnd_r, rnd_cd, out_valid, out_block
    );

    modport slave (
        input  in_valid, in_decrypt, in_block, in_key_cd, f_result, out_ready,
        output in_ready, rnd_active, rnd_idx, rnd_r, rnd_cd, out_valid, out_block
    );
endinterface

// File: rtl/des_round_ctrl.sv
// ---------------------------------------------------------------------------
// des_round_ctrl
// Iterative DES round sequencer. It runs one external combinational round
// function f over 16 rounds, one round per clock. It owns the L/R halves,
// the C/D key-schedule registers, the round counter and both handshakes.
//   clk, rst : core clock; asynchronous active-high reset
//   bus      : des_round_ctrl_if.slave
//              in_*   post-IP block {L0,R0} and post-PC-1 key {C0,D0}
//              rnd_*  round datapath drive (R half, {C,D}, round index)
//              f_result  f(R,K) returned in the same cycle
//              out_*  pre-FP result {R16,L16}
// ---------------------------------------------------------------------------
module des_round_ctrl #(
    // Bit i-1 set: encrypt round i rotates by 1, otherwise by 2.
    parameter logic [15:0] SHIFT_MASK = 16'h8103
) (
    input  logic            clk,
    input  logic            rst,
    des_round_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q;
    logic [31:0] l_q;
    logic [31:0] r_q;
    logic [55:0] cd_q;
    logic [55:0] cd_d;
    logic        mode_q;          // 1 = decrypt, latched on accept
    logic [3:0]  rnd_idx_q;
    logic        in_ready_q;
    logic        rnd_active_q;
    logic        out_valid_q;
    logic [63:0] out_block_q;
    logic        next_single;     // next round uses a 1-bit rotation

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
        rotl28 = two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
        rotr28 = two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    // The key schedule is pre-rotated for round k = rnd_idx+2. The encrypt
    // direction reads the mask forward. The decrypt direction undoes the
    // encrypt shifts in reverse order, so it reads the mask backward. Round
    // 17 does not exist, so the last cycle's rotation amount is unused.
    always_comb begin
        next_single = 1'b1;
        if (mode_q) begin
            next_single = SHIFT_MASK[4'd15 - rnd_idx_q];
        end else if (rnd_idx_q != 4'd15) begin
            next_single = SHIFT_MASK[rnd_idx_q + 4'd1];
        end

        if (mode_q) begin
            cd_d = {rotr28(cd_q[55:28], !next_single), rotr28(cd_q[27:0], !next_single)};
        end else begin
            cd_d = {rotl28(cd_q[55:28], !next_single), rotl28(cd_q[27:0], !next_single)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            l_q          <= '0;
            r_q          <= '0;
            cd_q         <= '0;
            mode_q       <= 1'b0;
            rnd_idx_q    <= '0;
            in_ready_q   <= 1'b1;
            rnd_active_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_block_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        l_q          <= bus.in_block[63:32];
                        r_q          <= bus.in_block[31:0];
                        mode_q       <= bus.in_decrypt;
                        // Encrypt round 1 always shifts by 1. Decrypt round 1
                        // uses K16, and the total of all 16 shifts is 28, so
                        // K16 equals the unrotated key.
                        cd_q         <= bus.in_decrypt ? bus.in_key_cd
                                        : {rotl28(bus.in_key_cd[55:28], 1'b0),
                                           rotl28(bus.in_key_cd[27:0], 1'b0)};
                        rnd_idx_q    <= '0;
                        in_ready_q   <= 1'b0;
                        rnd_active_q <= 1'b1;
                        state_q      <= RUN;
                    end
                end
                RUN: begin
                    l_q       <= r_q;
                    r_q       <= l_q ^ bus.f_result;
                    cd_q      <= cd_d;
                    rnd_idx_q <= rnd_idx_q + 4'd1;
                    if (rnd_idx_q == 4'd15) begin
                        // Emit {R16,L16}: the final round's swap is undone.
                        out_block_q  <= {l_q ^ bus.f_result, r_q};
                        out_valid_q  <= 1'b1;
                        rnd_active_q <= 1'b0;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    in_ready_q   <= 1'b1;
                    rnd_active_q <= 1'b0;
                    out_valid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.rnd_active = rnd_active_q;
    assign bus.rnd_idx    = rnd_idx_q;
    assign bus.rnd_r      = r_q;
    assign bus.rnd_cd     = cd_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_block  = out_block_q;

endmodule

// File: tb/tb_des_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_des_round_ctrl
// Directed bench for des_round_ctrl. The round function f is modelled here
// with E-expansion, PC-2, key XOR, the eight S-boxes and P. It is fed
// combinationally from rnd_r / rnd_cd.
// ---------------------------------------------------------------------------
module tb_des_round_ctrl;

    localparam logic [63:0] PT  = 64'hCC00CCFF_F0AAF0AA;
    localparam logic [63:0] CT  = 64'h0A4CD995_43423234;
    localparam logic [55:0] KEY = 56'hF0CCAAF_556678F;
    localparam logic [55:0] CD1 = 56'hE19955F_AACCF1E;
    localparam logic [55:0] CD2 = 56'hC332ABF_5599E3D;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    des_round_ctrl_if bus();

    des_round_ctrl #(.SHIFT_MASK(16'h8103)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Cumulative left shift of C/D at rounds 1..16 (FIPS-46 schedule).
    int cum_tab [16] = '{1, 2, 4, 6, 8, 10, 12, 14, 15, 17, 19, 21, 23, 25, 27, 28};

    int e_tab [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
                       16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
    int pc2_tab [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                         41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    int p_tab [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                       2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

    int sbox [8][64] = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,   0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
          4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,   15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
        '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,   3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
          0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,   13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
        '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,   13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
          13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,   1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
        '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,   13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
          10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,   3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
        '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,   14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
          4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,   11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
        '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,   10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
          9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,   4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
        '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,   13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
          1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,   6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
        '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,   1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
          7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,   2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}
    };

    // FIPS bit n (1 = MSB) of an N-bit word sits at vector index N-n.
    function automatic logic [31:0] f_model(input logic [31:0] r, input logic [55:0] cd);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] p;
        logic [5:0]  six;
        for (int i = 0; i < 48; i++) begin
            x[6'(47 - i)] = r[5'(32 - e_tab[i])] ^ cd[6'(56 - pc2_tab[i])];
        end
        for (int b = 0; b < 8; b++) begin
            six = x[6'(47 - 6 * b) -: 6];
            s[5'(31 - 4 * b) -: 4] = 4'(sbox[3'(b)][{six[5], six[0], six[4:1]}]);
        end
        for (int i = 0; i < 32; i++) begin
            p[5'(31 - i)] = s[5'(32 - p_tab[i])];
        end
        return p;
    endfunction

    function automatic logic [55:0] exp_cd(input logic [55:0] key, input int n);
        logic [27:0] c;
        logic [27:0] d;
        c = key[55:28];
        d = key[27:0];
        for (int i = 0; i < n; i++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        return {c, d};
    endfunction

    assign bus.f_result = f_model(bus.rnd_r, bus.rnd_cd);

    // Presents a block at a negedge and returns one negedge after the accept edge.
    task automatic accept_block(input logic [63:0] blk, input logic [55:0] key, input logic dec);
        bus.in_block   = blk;
        bus.in_key_cd  = key;
        bus.in_decrypt = dec;
        bus.in_valid   = 1'b1;
        @(negedge clk);
        bus.in_valid   = 1'b0;
    endtask

    // Steps negedges until out_valid is seen or the budget runs out.
    task automatic wait_out(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic out_handshake();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_decrypt = 1'b0; bus.in_block = '0; bus.in_key_cd = '0; bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        tests_run++; if (bus.rnd_active !== 1'b0) begin tests_failed++; $display("FAIL reset_rnd_active: got %b want 0", bus.rnd_active); end
        tests_run++; if (bus.rnd_idx !== 4'd0) begin tests_failed++; $display("FAIL reset_rnd_idx: got %0d want 0", bus.rnd_idx); end
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        tests_run++; if (bus.out_block !== 64'd0) begin tests_failed++; $display("FAIL reset_out_block: got %h want 0", bus.out_block); end
        tests_run++; if (bus.rnd_r !== 32'd0 || bus.rnd_cd !== 56'd0) begin tests_failed++; $display("FAIL reset_r_cd: got r=%h cd=%h want 0", bus.rnd_r, bus.rnd_cd); end
        rst = 1'b0;
        @(negedge clk);
        tests_run++; if (bus.in_ready !== 1'b1 || bus.rnd_active !== 1'b0) begin tests_failed++; $display("FAIL reset_release_idle: got ready=%b active=%b want 1/0", bus.in_ready, bus.rnd_active); end
    endtask

    task automatic test_encrypt_kat();
        tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL enc_ready_before: got %b want 1", bus.in_ready); end
        accept_block(PT, KEY, 1'b0);
        for (int k = 0; k < 16; k++) begin
            tests_run++;
            if (bus.rnd_active !== 1'b1 || bus.rnd_idx !== 4'(k) || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL enc_round_ctl[%0d]: got active=%b idx=%0d ready=%b ovalid=%b want 1/%0d/0/0", k, bus.rnd_active, bus.rnd_idx, bus.in_ready, bus.out_valid, k);
            end
            tests_run++; if (bus.rnd_cd !== exp_cd(KEY, cum_tab[4'(k)])) begin tests_failed++; $display("FAIL enc_cd[%0d]: got %h want %h", k, bus.rnd_cd, exp_cd(KEY, cum_tab[4'(k)])); end
            if (k == 0) begin
                tests_run++; if (bus.rnd_cd !== CD1) begin tests_failed++; $display("FAIL enc_cd_round1: got %h want %h", bus.rnd_cd, CD1); end
            end
            if (k == 1) begin
                tests_run++; if (bus.rnd_cd !== CD2) begin tests_failed++; $display("FAIL enc_cd_round2: got %h want %h", bus.rnd_cd, CD2); end
            end
            @(negedge clk);
        end
        tests_run++; if (bus.out_valid !== 1'b1 || bus.rnd_active !== 1'b0) begin tests_failed++; $display("FAIL enc_latency: got ovalid=%b active=%b want 1/0 at 16 cycles", bus.out_valid, bus.rnd_active); end
        tests_run++; if (bus.out_block !== CT) begin tests_failed++; $display("FAIL enc_result: got %h want %h", bus.out_block, CT); end
        $display("[TB] encrypt  in=%h key=%h out=%h", PT, KEY, bus.out_block);
        out_handshake();
        tests_run++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL enc_handshake: got ovalid=%b ready=%b want 0/1", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_decrypt();
        accept_block(CT, KEY, 1'b1);
        for (int k = 0; k < 16; k++) begin
            tests_run++; if (bus.rnd_cd !== exp_cd(KEY, cum_tab[4'(15 - k)])) begin tests_failed++; $display("FAIL dec_cd[%0d]: got %h want %h", k, bus.rnd_cd, exp_cd(KEY, cum_tab[4'(15 - k)])); end
            if (k == 0) begin
                tests_run++; if (bus.rnd_cd !== KEY) begin tests_failed++; $display("FAIL dec_cd_first: got %h want %h", bus.rnd_cd, KEY); end
            end
            if (k == 15) begin
                tests_run++; if (bus.rnd_cd !== CD1) begin tests_failed++; $display("FAIL dec_cd_last: got %h want %h", bus.rnd_cd, CD1); end
            end
            @(negedge clk);
        end
        tests_run++; if (bus.out_valid !== 1'b1 || bus.out_block !== PT) begin tests_failed++; $display("FAIL dec_result: got valid=%b out=%h want 1/%h", bus.out_valid, bus.out_block, PT); end
        $display("[TB] decrypt  in=%h key=%h out=%h", CT, KEY, bus.out_block);
        out_handshake();
    endtask

    task automatic test_backpressure();
        bit ok;
        accept_block(PT, KEY, 1'b0);
        wait_out(20, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL bp_first_timeout: got no out_valid want out_valid within 20 cycles"); end
        bus.in_block = CT; bus.in_key_cd = KEY; bus.in_decrypt = 1'b1; bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.out_block !== CT || bus.in_ready !== 1'b0 || bus.rnd_active !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: got valid=%b out=%h ready=%b active=%b want 1/%h/0/0", i, bus.out_valid, bus.out_block, bus.in_ready, bus.rnd_active, CT);
            end
            @(negedge clk);
        end
        $display("[TB] bp-hold  out=%h held 5 cycles", bus.out_block);
        out_handshake();
        tests_run++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.rnd_active !== 1'b0) begin tests_failed++; $display("FAIL bp_after_hs: got valid=%b ready=%b active=%b want 0/1/0", bus.out_valid, bus.in_ready, bus.rnd_active); end
        @(negedge clk);
        tests_run++; if (bus.rnd_active !== 1'b1 || bus.rnd_idx !== 4'd0 || bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_second_accept: got active=%b idx=%0d ready=%b want 1/0/0", bus.rnd_active, bus.rnd_idx, bus.in_ready); end
        bus.in_valid = 1'b0;
        wait_out(20, ok);
        tests_run++; if (!ok || bus.out_block !== PT) begin tests_failed++; $display("FAIL bp_second_result: got ok=%b out=%h want 1/%h", ok, bus.out_block, PT); end
        $display("[TB] bp-2nd   in=%h dec=1 out=%h", CT, bus.out_block);
        out_handshake();
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen;
        accept_block(PT, KEY, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.rnd_idx === 4'd7) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL rstmid_reach_idx7: got idx=%0d want 7", bus.rnd_idx); end
        #2 rst = 1'b1;
        #1;
        tests_run++; if (bus.in_ready !== 1'b1 || bus.rnd_active !== 1'b0 || bus.rnd_idx !== 4'd0) begin tests_failed++; $display("FAIL rstmid_ctl: got ready=%b active=%b idx=%0d want 1/0/0", bus.in_ready, bus.rnd_active, bus.rnd_idx); end
        tests_run++; if (bus.out_valid !== 1'b0 || bus.out_block !== 64'd0) begin tests_failed++; $display("FAIL rstmid_out: got valid=%b out=%h want 0/0", bus.out_valid, bus.out_block); end
        tests_run++; if (bus.rnd_r !== 32'd0 || bus.rnd_cd !== 56'd0) begin tests_failed++; $display("FAIL rstmid_regs: got r=%h cd=%h want 0/0", bus.rnd_r, bus.rnd_cd); end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        tests_run++; if (seen) begin tests_failed++; $display("FAIL rstmid_no_out: got out_valid pulse want none"); end
        accept_block(PT, KEY, 1'b0);
        wait_out(20, ok);
        tests_run++; if (!ok || bus.out_block !== CT) begin tests_failed++; $display("FAIL rstmid_next_block: got ok=%b out=%h want 1/%h", ok, bus.out_block, CT); end
        $display("[TB] post-rst in=%h key=%h out=%h", PT, KEY, bus.out_block);
        out_handshake();
    endtask

    task automatic test_ignored_input();
        bit ok;
        accept_block(PT, KEY, 1'b0);
        for (int k = 0; k < 15; k++) begin
            tests_run++;
            if (bus.rnd_idx !== 4'(k) || bus.in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL ign_round[%0d]: got idx=%0d ready=%b want %0d/0", k, bus.rnd_idx, bus.in_ready, k);
            end
            bus.in_valid   = k[0];
            bus.in_block   = {$urandom(), $urandom()};
            bus.in_key_cd  = 56'({$urandom(), $urandom()});
            bus.in_decrypt = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        wait_out(5, ok);
        bus.in_valid = 1'b0;
        tests_run++; if (!ok || bus.out_block !== CT) begin tests_failed++; $display("FAIL ign_result: got ok=%b out=%h want 1/%h", ok, bus.out_block, CT); end
        $display("[TB] ignore   in=%h key=%h out=%h", PT, KEY, bus.out_block);
        out_handshake();
    endtask

    initial begin
        test_reset();
        test_encrypt_kat();
        test_decrypt();
        test_backpressure();
        test_reset_mid();
        test_ignored_input();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
